alu_seq_unit: RTL
=================

// Module: alu_seq_unit
// PURPOSE
//  Parametrised multi-cycle ALU for the MIPS datapath. It takes an operation code and two operands
//  through a valid/ready handshake. Single-cycle ops run in one cycle; MUL and DIV run on iterative
//  engines. Result and status flags are returned through a valid/ready handshake.
//  Sits between ID/EX operand latch and EX/MEM; the pipeline stalls while in_ready=0.
// PARAMETERS
//  WIDTH     32  datapath width in bits (even, >=4); MUL operands are the low WIDTH/2 bits
//  FUNCT_W    4  opcode width
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        op/a/b valid
//  in_ready   out  1        unit can accept an op this cycle
//  funct      in   FUNCT_W  opcode (table below)
//  a, b       in   WIDTH    operands
//  out_valid  out  1        result/flags valid
//  out_ready  in   1        consumer takes the result this cycle
//  result     out  WIDTH    result
//  zero       out  1        result == 0
//  carry      out  1        ADD carry-out / SUB no-borrow (a>=b unsigned); 0 for other ops
//  overflow   out  1        signed overflow for ADD/SUB; 0 for other ops
//  err        out  1        illegal opcode, or DIV with b==0
//  busy       out  1        FSM not IDLE
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-low.
//  Reset: FSM=IDLE; out_valid, result, zero, carry, overflow, err and busy are 0.
//   in_ready=1 after reset deasserts. Reset in mid-op aborts the op and discards it.
//  Opcodes:
//   0000 AND  a&b          0001 OR   a|b           0010 ADD  a+b
//   0110 SUB  a-b          0111 SLT  signed a<b -> 1/0   0011 NOT  ~a
//   1010 MUL  unsigned a[W/2-1:0]*b[W/2-1:0], full WIDTH product, shift-add
//   1011 DIV  unsigned a/b quotient, restoring algorithm
//  Any other code: result=0, err=1, single-cycle.
//  Arithmetic is mod 2^WIDTH.
//  FSM states: IDLE, MUL, DIV, DONE.
//   IDLE + accept (in_valid&in_ready): single-cycle op -> DONE with result latched; MUL -> MUL; DIV -> DIV.
//   MUL: one partial-product bit per cycle, WIDTH/2 cycles, then DONE.
//   DIV: one quotient bit per cycle, WIDTH cycles, then DONE.
//   DONE: out_valid=1; on out_ready -> IDLE, or straight to a new op if one is accepted that cycle.
//  in_ready = (state==IDLE) | (state==DONE & out_ready). Back-to-back single-cycle ops give 1 result/cycle.
//  Latency from accept edge N: single-cycle ops have out_valid at N+1; MUL at N+1+WIDTH/2; DIV at N+1+WIDTH.
//  Operands and funct are captured on accept; later input changes do not affect an op in flight.
//  Backpressure: while out_valid & !out_ready, result and all flags hold stable.
//  zero is computed on the final result for every op, including MUL, DIV and illegal codes.
//  DIV with b==0: no iteration; result={WIDTH{1}}, err=1, single-cycle latency.
//  MUL with either operand's low half ==0 still takes the full WIDTH/2 cycles (fixed latency).
//  in_valid while busy is ignored; the source must hold it until in_ready.
// TESTING (WIDTH=32)
//  1. ADD a=7FFFFFFF b=1, out_ready=1 -> out_valid at N+1, result 80000000, overflow=1, carry=0, zero=0.
//  2. SUB a=5 b=5 -> result 0, zero=1, carry=1. SLT a=FFFFFFFF b=1 -> result 1.
//  3. MUL a=0000FFFF b=0000FFFF -> out_valid exactly N+17, result FFFE0001; in_ready=0 during cycles N+1..N+16.
//  4. DIV a=100 b=7 -> result 24 (0x24 for a=0x100), out_valid at N+33. DIV b=0 -> N+1, result FFFFFFFF, err=1.
//  5. Hold out_ready=0 for 5 cycles after ADD 3+4 -> result stays 7 and out_valid stays 1.
//     Raising out_ready together with a new in_valid OR op is accepted the same cycle.
//  6. rst_n pulsed low mid-DIV (cycle N+10) -> outputs 0 immediately (async). After release the next
//     ADD 1+1 returns 2 at N'+1. Illegal funct 1111 -> result 0, err=1, zero=1.

Source files
------------

// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_unit
//  Purpose  : Multi-cycle ALU for the MIPS datapath. The unit accepts an
//             opcode and two operands through a valid/ready handshake.
//             Logic and add/sub ops finish in one cycle. MUL runs on an
//             iterative shift-add engine (WIDTH/2 cycles). DIV runs on a
//             restoring divider (WIDTH cycles). The result and its status
//             flags are returned through a second valid/ready handshake.
//  Ports    : clk, rst_n                 clock, async active-low reset
//             in_valid_i / in_ready_o    operation handshake
//             funct_i, a_i, b_i          opcode and operands
//             out_valid_o / out_ready_i  result handshake
//             result_o, zero_o, carry_o,
//             overflow_o, err_o          result and status flags
//             busy_o                     FSM not idle
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq_unit #(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   result_o,
    output logic               zero_o,
    output logic               carry_o,
    output logic               overflow_o,
    output logic               err_o,
    output logic               busy_o
);

    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [FUNCT_W-1:0] c_FN_AND = FUNCT_W'(4'b0000);
    localparam logic [FUNCT_W-1:0] c_FN_OR  = FUNCT_W'(4'b0001);
    localparam logic [FUNCT_W-1:0] c_FN_ADD = FUNCT_W'(4'b0010);
    localparam logic [FUNCT_W-1:0] c_FN_NOT = FUNCT_W'(4'b0011);
    localparam logic [FUNCT_W-1:0] c_FN_SUB = FUNCT_W'(4'b0110);
    localparam logic [FUNCT_W-1:0] c_FN_SLT = FUNCT_W'(4'b0111);
    localparam logic [FUNCT_W-1:0] c_FN_MUL = FUNCT_W'(4'b1010);
    localparam logic [FUNCT_W-1:0] c_FN_DIV = FUNCT_W'(4'b1011);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               carry_q;
    logic               ovf_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;

    // Multiply engine: multiplicand shifts left, multiplier shifts right.
    logic [WIDTH-1:0]   mcand_q;
    logic [HALF-1:0]    mplier_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;

    // Divide engine: dividend shifts out of quo_q as quotient bits shift in.
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH:0]     w_rem_diff;
    logic               w_div_ge;

    // Single-cycle datapath decoded straight from the inputs.
    logic [WIDTH:0]     w_add;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_sc_result;
    logic               w_sc_carry;
    logic               w_sc_ovf;
    logic               w_sc_err;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_accept;

    assign in_ready_o  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_i);
    assign w_accept    = in_valid_i & in_ready_o;
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign carry_o     = carry_q;
    assign overflow_o  = ovf_q;
    assign err_o       = err_q;

    assign w_add = {1'b0, a_i} + {1'b0, b_i};
    assign w_sub = a_i - b_i;

    always_comb begin
        w_sc_result = '0;
        w_sc_carry  = 1'b0;
        w_sc_ovf    = 1'b0;
        w_sc_err    = 1'b0;
        w_is_mul    = 1'b0;
        w_is_div    = 1'b0;
        case (funct_i)
            c_FN_AND: w_sc_result = a_i & b_i;
            c_FN_OR:  w_sc_result = a_i | b_i;
            c_FN_NOT: w_sc_result = ~a_i;
            c_FN_ADD: begin
                w_sc_result = w_add[WIDTH-1:0];
                w_sc_carry  = w_add[WIDTH];
                w_sc_ovf    = (a_i[WIDTH-1] == b_i[WIDTH-1]) &
                              (w_add[WIDTH-1] != a_i[WIDTH-1]);
            end
            c_FN_SUB: begin
                w_sc_result = w_sub;
                // Carry doubles as "no borrow", i.e. a >= b unsigned.
                w_sc_carry  = (a_i >= b_i);
                w_sc_ovf    = (a_i[WIDTH-1] != b_i[WIDTH-1]) &
                              (w_sub[WIDTH-1] != a_i[WIDTH-1]);
            end
            c_FN_SLT: w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            c_FN_MUL: w_is_mul = 1'b1;
            c_FN_DIV: begin
                // Divide by zero never enters the engine.
                if (b_i == '0) begin
                    w_sc_result = '1;
                    w_sc_err    = 1'b1;
                end else begin
                    w_is_div = 1'b1;
                end
            end
            default:  w_sc_err = 1'b1;
        endcase
    end

    // One shift-add step.
    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // One restoring-division step. The partial remainder is always below
    // 2*divisor, so the top bit of the (WIDTH+1)-bit difference is set
    // exactly when the trial subtraction goes negative.
    assign w_rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, dvsr_q};
    assign w_div_ge    = ~w_rem_diff[WIDTH];
    assign rem_d       = w_div_ge ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign quo_d       = {quo_q[WIDTH-2:0], w_div_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
        end else if (w_accept) begin
            // Accept happens from IDLE, or from DONE while the consumer
            // takes the previous result in the same cycle.
            if (w_is_mul) begin
                state_q  <= S_MUL;
                mcand_q  <= {{(WIDTH-HALF){1'b0}}, a_i[HALF-1:0]};
                mplier_q <= b_i[HALF-1:0];
                acc_q    <= '0;
                cnt_q    <= CNT_W'(HALF - 1);
            end else if (w_is_div) begin
                state_q  <= S_DIV;
                quo_q    <= a_i;
                rem_q    <= '0;
                dvsr_q   <= b_i;
                cnt_q    <= CNT_W'(WIDTH - 1);
            end else begin
                state_q  <= S_DONE;
                result_q <= w_sc_result;
                zero_q   <= (w_sc_result == '0);
                carry_q  <= w_sc_carry;
                ovf_q    <= w_sc_ovf;
                err_q    <= w_sc_err;
            end
        end else begin
            case (state_q)
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    // Fixed iteration count even when an operand is zero.
                    if (cnt_q == '0) begin
                        state_q  <= S_DONE;
                        result_q <= acc_d;
                        zero_q   <= (acc_d == '0);
                        carry_q  <= 1'b0;
                        ovf_q    <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                S_DIV: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q  <= S_DONE;
                        result_q <= quo_d;
                        zero_q   <= (quo_d == '0);
                        carry_q  <= 1'b0;
                        ovf_q    <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                S_DONE: begin
                    // Result and flags hold until the consumer takes them.
                    if (out_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
